// File: rtl/fifo_frame_packer_if.sv
// ============================================================================
// Module      : fifo_frame_packer_if
// Description : FIFO read port and framed valid/ready output stream bundle.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface fifo_frame_packer_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  fifo_empty;
    logic [DATA_WIDTH-1:0] fifo_data;
    logic                  fifo_rd_en;
    logic                  m_valid;
    logic                  m_ready;
    logic [DATA_WIDTH-1:0] m_data;
    logic                  m_last;

    // Packer side: consumes the FIFO, drives the output stream.
    modport master (
        input  fifo_empty,
        input  fifo_data,
        input  m_ready,
        output fifo_rd_en,
        output m_valid,
        output m_data,
        output m_last
    );

    // Environment side: the FIFO plus the downstream transmitter.
    modport slave (
        output fifo_empty,
        output fifo_data,
        output m_ready,
        input  fifo_rd_en,
        input  m_valid,
        input  m_data,
        input  m_last
    );
endinterface

`default_nettype wire

// File: rtl/fifo_frame_packer.sv
// ============================================================================
// Module      : fifo_frame_packer
// Description : Drains FIFO words into HEADER/length/payload/checksum frames.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fifo_frame_packer #(
    parameter int                    DATA_WIDTH = 8,
    parameter int                    FRAME_LEN  = 4,
    parameter logic [DATA_WIDTH-1:0] HEADER     = 'hA5
) (
    input  wire logic              clk,
    input  wire logic              rst,
    fifo_frame_packer_if.master    bus,
    output logic                   busy,
    output logic [15:0]            frame_cnt
);

    localparam logic [2:0] c_IDLE = 3'd0;
    localparam logic [2:0] c_LEN  = 3'd1;
    localparam logic [2:0] c_PAY  = 3'd2;
    localparam logic [2:0] c_CSUM = 3'd3;
    localparam logic [2:0] c_DONE = 3'd4;

    localparam logic [DATA_WIDTH-1:0] c_FRAME_LEN_W = DATA_WIDTH'(FRAME_LEN);

    logic [2:0]            r_state;
    logic                  r_m_valid;
    logic [DATA_WIDTH-1:0] r_m_data;
    logic                  r_m_last;
    logic [DATA_WIDTH-1:0] r_csum;
    logic [DATA_WIDTH-1:0] r_words_read;
    logic [DATA_WIDTH-1:0] r_words_captured;
    logic                  r_rd_inflight;
    logic [15:0]           r_frame_cnt;

    logic                  w_out_free;
    logic                  w_handshake;
    logic                  w_rd_en;

    assign w_out_free  = !r_m_valid || bus.m_ready;
    assign w_handshake = r_m_valid && bus.m_ready;

    // A read is only issued when the output register is guaranteed free on
    // the capture cycle, so captured data never has to wait or be dropped.
    assign w_rd_en = (r_state == c_PAY) && !bus.fifo_empty && !r_rd_inflight
                     && w_out_free && (r_words_read < c_FRAME_LEN_W);

    assign bus.fifo_rd_en = w_rd_en;
    assign bus.m_valid    = r_m_valid;
    assign bus.m_data     = r_m_data;
    assign bus.m_last     = r_m_last;
    assign frame_cnt      = r_frame_cnt;
    assign busy           = (r_state != c_IDLE) || r_m_valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state          <= c_IDLE;
            r_m_valid        <= 1'b0;
            r_m_data         <= '0;
            r_m_last         <= 1'b0;
            r_csum           <= '0;
            r_words_read     <= '0;
            r_words_captured <= '0;
            r_rd_inflight    <= 1'b0;
            r_frame_cnt      <= '0;
        end else begin
            r_rd_inflight <= w_rd_en;
            if (w_rd_en) begin
                r_words_read <= r_words_read + 1'b1;
            end

            // Later assignments in this block override the handshake clear,
            // which keeps m_valid high when a new beat loads in the same cycle.
            if (w_handshake) begin
                r_m_valid <= 1'b0;
                r_m_last  <= 1'b0;
            end

            if (r_rd_inflight) begin
                r_m_data         <= bus.fifo_data;
                r_m_valid        <= 1'b1;
                r_m_last         <= 1'b0;
                r_csum           <= r_csum + bus.fifo_data;
                r_words_captured <= r_words_captured + 1'b1;
            end

            case (r_state)
                c_IDLE: begin
                    if (!bus.fifo_empty && w_out_free) begin
                        r_m_data  <= HEADER;
                        r_m_valid <= 1'b1;
                        r_state   <= c_LEN;
                    end
                end
                c_LEN: begin
                    if (w_out_free) begin
                        r_m_data         <= c_FRAME_LEN_W;
                        r_m_valid        <= 1'b1;
                        r_csum           <= '0;
                        r_words_read     <= '0;
                        r_words_captured <= '0;
                        r_state          <= c_PAY;
                    end
                end
                c_PAY: begin
                    if (r_words_captured == c_FRAME_LEN_W) begin
                        r_state <= c_CSUM;
                    end
                end
                c_CSUM: begin
                    if (w_out_free) begin
                        r_m_data  <= r_csum;
                        r_m_valid <= 1'b1;
                        r_m_last  <= 1'b1;
                        r_state   <= c_DONE;
                    end
                end
                c_DONE: begin
                    if (w_handshake && r_m_last) begin
                        r_frame_cnt <= r_frame_cnt + 16'd1;
                        r_state     <= c_IDLE;
                    end
                end
                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: doc/fifo_frame_packer.md
Name: fifo_frame_packer

Overview:
- Downstream consumer of the synchronous byte FIFO.
- Drains payload words from the FIFO read port and emits fixed-length framed packets on a valid/ready output stream.
- Frame format: HEADER, length, FRAME_LEN payload words, checksum.
- Sits between the FIFO and the serial/link transmitter, so the transmitter sees only complete, self-delimiting frames.

Parameters:
- DATA_WIDTH, 8, width of FIFO words and of every output beat.
- FRAME_LEN, 4, payload words per frame. Legal range 1..255; must fit in DATA_WIDTH bits.
- HEADER, 8'hA5, constant first beat of every frame; DATA_WIDTH bits.

Ports:
- clk  input  1  rising-edge clock shared with the FIFO.
- rst  input  1  asynchronous, active-high reset.
- fifo_empty  input  1  FIFO empty flag.
- fifo_data  input  DATA_WIDTH  FIFO registered read data; valid the cycle after an accepted read.
- fifo_rd_en  output  1  FIFO read request.
- m_valid  output  1  output beat valid.
- m_ready  input  1  downstream accepts the beat.
- m_data  output  DATA_WIDTH  output beat.
- m_last  output  1  high on the checksum beat (final beat of a frame).
- busy  output  1  high whenever state != IDLE or m_valid = 1.
- frame_cnt  output  16  completed frames; wraps 16'hFFFF -> 0.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high.
- Reset values: state=IDLE, m_valid=0, m_data=0, m_last=0, fifo_rd_en=0, frame_cnt=0, internal word count=0, checksum=0, rd_inflight=0.
- Output register:
  - out_free = !m_valid || m_ready.
  - A handshake occurs when m_valid && m_ready.
  - While m_valid && !m_ready, m_data and m_last are held stable.
  - m_valid drops after a handshake unless a new beat loads in the same cycle.
- FIFO read rule:
  - fifo_rd_en is combinational and high only when state=PAY, !fifo_empty, !rd_inflight, out_free, and words_read < FRAME_LEN.
  - rd_inflight is set the cycle after fifo_rd_en=1 and clears after one cycle.
  - While rd_inflight=1: m_data <= fifo_data, m_valid <= 1, m_last <= 0, checksum <= checksum + fifo_data, words_captured increments.
  - Because of the out_free condition, the output register is always free when captured data arrives.
  - The packer never reads an empty FIFO and never drops a captured word.
- FSM:
  - IDLE: if !fifo_empty && out_free, load m_data=HEADER and m_valid=1, then go to LEN. Otherwise stay in IDLE; m_valid clears on handshake.
  - LEN: when out_free, load m_data=FRAME_LEN, clear checksum and counters, go to PAY.
  - PAY: issue reads per the read rule. When words_captured reaches FRAME_LEN (updated on the capture cycle), go to CSUM on the next cycle.
  - CSUM: when out_free, load m_data=checksum and m_last=1, go to DONE.
  - DONE: on the m_last handshake, frame_cnt increments and the FSM returns to IDLE. m_last clears with m_valid.
- Arithmetic: checksum is the sum of the payload words modulo 2^DATA_WIDTH. HEADER and length are excluded from the sum.
- Throughput:
  - Header and length beats: at most one per cycle.
  - Payload: at most one word per 2 cycles (issue cycle, then capture cycle).
  - Best-case latency from fifo_empty falling in IDLE to the header appearing on m_valid: 1 cycle.
- FIFO starvation mid-frame: the packer waits in PAY indefinitely with no timeout and no padding. m_valid drops after the last captured word is accepted.
- Backpressure: m_ready=0 stalls all state progress that needs out_free. No FIFO read is issued while the output is occupied and not accepted.
- Reset mid-frame: all state returns to reset values immediately; the partial frame is abandoned. Words already read from the FIFO are lost. The next frame starts with HEADER.
- Simultaneous events: a handshake on one beat and a load of the next beat in the same cycle is legal and keeps m_valid=1.

Test Plan:
- Basic frame: FIFO holds 01 02 03 04, m_ready=1 constantly -> m_data sequence A5 04 01 02 03 04 0A. m_last only on 0A. frame_cnt=1. busy=0 afterwards.
- Checksum wrap: payload FF FF FF FF -> checksum beat FC. Payload 80 80 00 00 -> 00.
- Backpressure: toggle m_ready randomly (about 50%) during the basic frame -> identical beat sequence with no duplicates or drops. m_data stable whenever m_valid && !m_ready. fifo_rd_en never high while m_valid && !m_ready.
- Starvation: FIFO supplies 2 words, stays empty 20 cycles, then 2 more -> packer holds in PAY with fifo_rd_en=0 while empty, then completes the frame with the correct checksum. fifo_rd_en is never high while fifo_empty=1.
- Reset mid-frame: assert rst asynchronously after the 2nd payload beat -> all outputs go to 0 without waiting for clk. After release with FIFO holding 05 06 07 08 -> A5 04 05 06 07 08 1A, frame_cnt=1.
- Back-to-back: 8 words queued (1..8), m_ready=1 -> two frames with checksums 0A and 1A. frame_cnt=2. No idle beat beyond the required per-state out_free timing.
